// File: rtl/clock_pkg.sv
// Shared types and constants for the clock mode/time-set controller.
// Mode encoding, FSM states and the digit groups used by the blink mask.
package clock_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_SET_HR  = 2'd1;
    localparam logic [1:0] MODE_SET_MIN = 2'd2;

    typedef enum logic [1:0] {
        RUN     = MODE_RUN,
        SET_HR  = MODE_SET_HR,
        SET_MIN = MODE_SET_MIN
    } state_t;

    // Digit-enable groups on the 8-digit scan bus; [7:6] are unused digits.
    localparam logic [7:0] HR_DIGITS  = 8'h30;
    localparam logic [7:0] MIN_DIGITS = 8'h0C;
    localparam logic [7:0] SEC_DIGITS = 8'h03;

    // Only the field being edited blinks, and only in its dark phase.
    function automatic logic [7:0] blank_for(state_t s, logic phase);
        logic [7:0] m;
        m = 8'h00;
        if (!phase) begin
            if (s == SET_HR)  m = HR_DIGITS;
            if (s == SET_MIN) m = MIN_DIGITS;
        end
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press strobe.
// The accepted level only flips after DEBOUNCE_CYC consecutive cycles of disagreement.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC);

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= s2;
                cnt   <= '0;
                press <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/time-set controller for the 12-hour clock: debounced MODE/INC buttons,
// RUN -> SET_HR -> SET_MIN -> RUN sequencing, INC auto-repeat, timeout and blink mask.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = 100000,
    parameter int HOLD_CYC      = 5000000,
    parameter int REPEAT_CYC    = 1000000,
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       blink_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       run_en,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [7:0] blank_mask,
    output logic [1:0] mode
);
    localparam int RMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam int TW   = $clog2(TIMEOUT_TICKS + 1);

    logic mode_press, mode_level_unused;
    logic inc_press, inc_level;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .level (mode_level_unused),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_db (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    // Auto-repeat: first strobe HOLD_CYC after the press, then every REPEAT_CYC.
    logic [RW-1:0] rep_cnt;
    logic          rep_armed, rep_first, inc_rep;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
            rep_first <= 1'b0;
            inc_rep   <= 1'b0;
        end else begin
            inc_rep <= 1'b0;
            if (inc_press) begin
                rep_armed <= 1'b1;
                rep_first <= 1'b1;
                rep_cnt   <= RW'(1);
            end else if (!inc_level) begin
                rep_armed <= 1'b0;
            end else if (rep_armed) begin
                if (rep_cnt == (rep_first ? RW'(HOLD_CYC - 1) : RW'(REPEAT_CYC - 1))) begin
                    inc_rep   <= 1'b1;
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + RW'(1);
                end
            end
        end
    end

    logic inc_ev;
    assign inc_ev = inc_press | inc_rep;

    state_t        state;
    logic          phase;
    logic [TW-1:0] tmo;

    // MODE is tested first so a coincident INC (press or repeat) is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= RUN;
            phase   <= 1'b1;
            tmo     <= '0;
            inc_hr  <= 1'b0;
            inc_min <= 1'b0;
            clr_sec <= 1'b0;
        end else begin
            inc_hr  <= 1'b0;
            inc_min <= 1'b0;
            clr_sec <= 1'b0;
            unique case (state)
                RUN: begin
                    if (mode_press) begin
                        state <= SET_HR;
                        phase <= 1'b1;
                        tmo   <= '0;
                    end
                end
                SET_HR, SET_MIN: begin
                    if (mode_press) begin
                        phase <= 1'b1;
                        tmo   <= '0;
                        if (state == SET_HR) begin
                            state <= SET_MIN;
                        end else begin
                            state   <= RUN;
                            clr_sec <= 1'b1;
                        end
                    end else if (inc_ev) begin
                        inc_hr  <= (state == SET_HR);
                        inc_min <= (state == SET_MIN);
                        tmo     <= '0;
                        phase   <= 1'b1;
                    end else if (blink_tick) begin
                        if (tmo >= TW'(TIMEOUT_TICKS - 1)) begin
                            state   <= RUN;
                            clr_sec <= 1'b1;
                            phase   <= 1'b1;
                            tmo     <= TW'(TIMEOUT_TICKS);
                        end else begin
                            tmo   <= tmo + TW'(1);
                            phase <= ~phase;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign run_en     = (state == RUN);
    assign mode       = state;
    assign blank_mask = blank_for(state, phase);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: cycle model of button timing and set-mode rules,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_clock_set_ctrl;
    localparam int DEB = 4;
    localparam int HOLD = 16;
    localparam int REP = 8;
    localparam int TO = 3;

    logic       clk, reset, blink_tick, btn_mode, btn_inc;
    logic       run_en, inc_hr, inc_min, clr_sec;
    logic [7:0] blank_mask;
    logic [1:0] mode;

    clock_set_ctrl #(
        .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLD), .REPEAT_CYC(REP), .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk), .reset(reset), .blink_tick(blink_tick),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .run_en(run_en), .inc_hr(inc_hr), .inc_min(inc_min), .clr_sec(clr_sec),
        .blank_mask(blank_mask), .mode(mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int n_hr = 0, n_min = 0, n_clr = 0;
    int hr_log[$];
    logic [1:0] after_mask[$];
    bit prev_hr = 1'b0;

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: index 0 = MODE button, 1 = INC button. st: 0 RUN, 1 SET_HR, 2 SET_MIN.
    int m_s1[2], m_s2[2], m_acc[2], m_run[2];
    bit m_prs[2];
    bit m_rep;
    int t_press;
    int st, tmo;
    bit ph, e_hr, e_min, e_clr;

    task model_step();
        bit mev, iev, new_rep;
        bit prs_new[2];
        int raw[2];
        int el;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_run[b] = 0; m_prs[b] = 0;
            end
            m_rep = 0; t_press = -1; st = 0; ph = 1; tmo = 0;
            e_hr = 0; e_min = 0; e_clr = 0;
            return;
        end
        mev = m_prs[0];
        iev = m_prs[1] | m_rep;
        e_hr = 0; e_min = 0; e_clr = 0;
        if (mev) begin
            ph = 1; tmo = 0;
            if (st == 2) begin st = 0; e_clr = 1; end
            else st = st + 1;
        end else if (st != 0) begin
            if (iev) begin
                e_hr = (st == 1); e_min = (st == 2); tmo = 0; ph = 1;
            end else if (blink_tick) begin
                tmo++; ph = !ph;
                if (tmo >= TO) begin st = 0; e_clr = 1; ph = 1; end
            end
        end
        new_rep = 0;
        if (t_press >= 0) begin
            if (m_acc[1] == 0) t_press = -1;
            else begin
                el = cyc - t_press;
                if (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0)) new_rep = 1;
            end
        end
        raw[0] = int'(btn_mode); raw[1] = int'(btn_inc);
        for (int b = 0; b < 2; b++) begin
            prs_new[b] = 0;
            if (m_s2[b] != m_acc[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin
                    m_acc[b] = m_s2[b]; m_run[b] = 0; prs_new[b] = (m_acc[b] == 1);
                end
            end else m_run[b] = 0;
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
            m_prs[b] = prs_new[b];
        end
        if (prs_new[1]) t_press = cyc;
        m_rep = new_rep;
    endtask

    initial begin
        logic [7:0] em;
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
            #1;
            em = (st == 1 && !ph) ? 8'h30 : (st == 2 && !ph) ? 8'h0C : 8'h00;
            check("run_en", 8'(run_en), 8'(st == 0));
            check("mode", 8'(mode), 8'(st));
            check("blank_mask", blank_mask, em);
            check("inc_hr", 8'(inc_hr), 8'(e_hr));
            check("inc_min", 8'(inc_min), 8'(e_min));
            check("clr_sec", 8'(clr_sec), 8'(e_clr));
            if (prev_hr) after_mask.push_back(blank_mask[5:4]);
            if (inc_hr) hr_log.push_back(cyc);
            prev_hr = inc_hr;
            n_hr += int'(inc_hr); n_min += int'(inc_min); n_clr += int'(clr_sec);
        end
    end

    task automatic press_mode();
        btn_mode = 1'b1;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic tick();
        blink_tick = 1'b1;
        @(negedge clk);
        blink_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int r0, hb, ab, cb, mb;
        int exp_off[4] = '{6, 22, 30, 38};
        logic [10:0] gl = 11'b10110111010;
        reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; blink_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset
        cb = n_clr;
        repeat (20) @(negedge clk);
        check("t1_run_en", 8'(run_en), 8'd1);
        check("t1_mode", 8'(mode), 8'd0);
        check("t1_mask", blank_mask, 8'h00);
        check("t1_strobes", 8'(n_hr + n_min + n_clr - cb), 8'd0);

        // 2: glitchy MODE, then stable
        for (int i = 10; i >= 0; i--) begin
            btn_mode = gl[i];
            @(negedge clk);
        end
        check("t2_glitch_mode", 8'(mode), 8'd0);
        btn_mode = 1'b1;
        repeat (10) @(negedge clk);
        check("t2_mode", 8'(mode), 8'd1);
        check("t2_run_en", 8'(run_en), 8'd0);
        btn_mode = 1'b0;
        repeat (10) @(negedge clk);
        check("t2_mode_hold", 8'(mode), 8'd1);

        // 3: INC held in SET_HR, ticks placed so the hours field is dark before each strobe
        hb = hr_log.size(); ab = after_mask.size();
        btn_inc = 1'b1; r0 = cyc + 1;
        for (int i = 0; i < 35; i++) begin
            blink_tick = (i == 4 || i == 18 || i == 27 || i == 34);
            @(negedge clk);
        end
        blink_tick = 1'b0; btn_inc = 1'b0;
        repeat (20) @(negedge clk);
        check("t3_pulses", 8'(hr_log.size() - hb), 8'd4);
        for (int i = 0; i < 4; i++)
            check("t3_offset", 8'((hb + i < hr_log.size()) ? hr_log[hb + i] - r0 : 255), 8'(exp_off[i]));
        for (int i = ab; i < after_mask.size(); i++)
            check("t3_mask_after", 8'(after_mask[i]), 8'd0);
        check("t3_mode", 8'(mode), 8'd1);

        // 4: back to RUN, then three MODE presses
        press_mode(); press_mode();
        check("t4_pre_mode", 8'(mode), 8'd0);
        cb = n_clr;
        press_mode();
        check("t4_mode1", 8'(mode), 8'd1);
        press_mode();
        check("t4_mode2", 8'(mode), 8'd2);
        check("t4_no_clr_yet", 8'(n_clr - cb), 8'd0);
        press_mode();
        check("t4_mode0", 8'(mode), 8'd0);
        check("t4_clr", 8'(n_clr - cb), 8'd1);
        check("t4_run_en", 8'(run_en), 8'd1);

        // 5: SET_MIN timeout with blinking
        press_mode(); press_mode();
        cb = n_clr;
        tick();
        check("t5_mask_t1", blank_mask, 8'h0C);
        tick();
        check("t5_mask_t2", blank_mask, 8'h00);
        check("t5_mode_t2", 8'(mode), 8'd2);
        tick();
        check("t5_mode_t3", 8'(mode), 8'd0);
        check("t5_clr", 8'(n_clr - cb), 8'd1);
        check("t5_run_en", 8'(run_en), 8'd1);

        // 6: simultaneous MODE+INC in SET_MIN, then reset mid-SET_HR
        press_mode(); press_mode();
        check("t6_pre_mode", 8'(mode), 8'd2);
        mb = n_min;
        btn_mode = 1'b1; btn_inc = 1'b1;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_mode", 8'(mode), 8'd0);
        check("t6_inc_min", 8'(n_min - mb), 8'd0);
        press_mode();
        tick();
        check("t6_mask_dark", blank_mask, 8'h30);
        cb = n_clr;
        #2 reset = 1'b1;
        #1;
        check("t6_rst_run_en", 8'(run_en), 8'd1);
        check("t6_rst_mode", 8'(mode), 8'd0);
        check("t6_rst_mask", blank_mask, 8'h00);
        check("t6_rst_strobes", 8'({inc_hr, inc_min, clr_sec}), 8'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_post_mode", 8'(mode), 8'd0);
        check("t6_no_clr", 8'(n_clr - cb), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
